codec_tx_if: RTL and testbench

Downstream output stage of the float datapath. Accepts 24-bit floats (1 sign, 7-bit exponent with bias 63, 16-bit mantissa) together with the arithmetic unit's underflow/overflow flags, and converts each one to signed 24-bit PCM (Q1.23, full scale ±1.0) with saturation. Samples are paired left/right and serialized to the audio codec as a standard I2S frame: 64 BCLK per frame, 24-bit MSB-first words, one-BCLK data delay after the LRCLK edge.

---
 rtl/codec_tx_if.sv | 138 +++++++++++++
 tb/tb_codec_tx_if.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_tx_if.sv
// Float24 to Q1.23 PCM converter with saturation, feeding an I2S transmitter
// (64 BCLK per frame, 24-bit MSB-first words, one-BCLK data delay).
module codec_tx_if #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] float_in,
    input  logic        float_in_underflow,
    input  logic        float_in_overflow,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        sat,
    output logic        underrun
);

    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [5:0]       bit_cnt;
    logic             slot_right;
    logic [23:0]      pl, pr, tx_l, tx_r;

    logic             pend_full_c;
    logic             xfer_c, fall_c, frame_start_c;
    logic [5:0]       nxt_cnt_c;
    logic [4:0]       k_c, bit_idx_c;
    logic [23:0]      word_c;
    logic             sdata_c;

    logic             sign_c;
    logic [6:0]       exp_c;
    logic [16:0]      mag_c;
    logic [23:0]      mag_sh_c;
    logic [23:0]      conv_c;
    logic             clip_c;

    assign pend_full_c   = !in_ready;
    assign xfer_c        = in_valid && in_ready;
    assign fall_c        = (div == DIV_MAX) && bclk;
    assign frame_start_c = fall_c && (bit_cnt == 6'd63);
    assign nxt_cnt_c     = bit_cnt + 6'd1;

    // Float24 -> Q1.23: value = {1,m} * 2^(e-56) in LSB units of the PCM word
    always_comb begin
        sign_c   = float_in[23];
        exp_c    = float_in[22:16];
        mag_c    = {1'b1, float_in[15:0]};
        mag_sh_c = '0;
        conv_c   = '0;
        clip_c   = 1'b0;
        if (float_in_underflow || exp_c == 7'd0) begin
            conv_c = '0;
        end else if (float_in_overflow || exp_c >= 7'd63) begin
            conv_c = sign_c ? 24'h800000 : 24'h7FFFFF;
            clip_c = 1'b1;
        end else begin
            if (exp_c >= 7'd56)
                mag_sh_c = 24'(mag_c) << (exp_c - 7'd56);
            else if (exp_c >= 7'd40)
                mag_sh_c = 24'(mag_c) >> (7'd56 - exp_c);
            else
                mag_sh_c = '0;
            conv_c = sign_c ? -mag_sh_c : mag_sh_c;
        end
    end

    // Serial bit for the position bit_cnt is about to advance to
    always_comb begin
        k_c       = nxt_cnt_c[4:0];
        word_c    = nxt_cnt_c[5] ? tx_r : tx_l;
        bit_idx_c = 5'd24 - k_c;
        sdata_c   = 1'b0;
        if (k_c != 5'd0 && k_c <= 5'd24)
            sdata_c = word_c[bit_idx_c];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div        <= '0;
            bclk       <= 1'b0;
            bit_cnt    <= 6'd63;
            lrclk      <= 1'b0;
            sdata      <= 1'b0;
            in_ready   <= 1'b1;
            slot_right <= 1'b0;
            pl         <= '0;
            pr         <= '0;
            tx_l       <= '0;
            tx_r       <= '0;
            sat        <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            sat      <= xfer_c && clip_c;
            underrun <= frame_start_c && !pend_full_c;

            if (div == DIV_MAX) begin
                div  <= '0;
                bclk <= ~bclk;
            end else begin
                div <= div + DIV_W'(1);
            end

            if (fall_c) begin
                bit_cnt <= nxt_cnt_c;
                lrclk   <= nxt_cnt_c[5];
                sdata   <= sdata_c;
            end

            if (xfer_c) begin
                if (slot_right)
                    pr <= conv_c;
                else
                    pl <= conv_c;
                slot_right <= ~slot_right;
                if (slot_right)
                    in_ready <= 1'b0;
            end

            // A pair completed in this same cycle waits for the next frame
            if (frame_start_c) begin
                if (pend_full_c) begin
                    tx_l     <= pl;
                    tx_r     <= pr;
                    in_ready <= 1'b1;
                end else begin
                    tx_l <= '0;
                    tx_r <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_codec_tx_if.sv
// Directed bench for codec_tx_if: decodes the I2S stream into frames and
// checks words, pulses, flow control and reset behaviour.
module tb_codec_tx_if;

    localparam int unsigned CLK_DIV = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] float_in;
    logic        float_in_underflow;
    logic        float_in_overflow;
    logic        in_valid;
    logic        in_ready;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        sat;
    logic        underrun;

    codec_tx_if #(.CLK_DIV(CLK_DIV)) dut (
        .clk                (clk),
        .rst                (rst),
        .float_in           (float_in),
        .float_in_underflow (float_in_underflow),
        .float_in_overflow  (float_in_overflow),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .bclk               (bclk),
        .lrclk              (lrclk),
        .sdata              (sdata),
        .sat                (sat),
        .underrun           (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic        ur;
        int          lr_err;
        int          pad_err;
    } frame_t;

    frame_t      frames[$];
    int          checks = 0;
    int          errors = 0;
    int          mon_pos = 63;
    int          mon_k;
    logic        mon_prev_bclk = 1'b0;
    logic [23:0] mon_sh, mon_l, mon_r;
    logic        mon_ur = 1'b0;
    int          mon_lr_err = 0, mon_pad_err = 0;
    int          frame_cnt = 0, ur_cnt = 0;

    // Stream decoder: tracks bit position from bclk falling edges
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_pos = 63; mon_prev_bclk = 1'b0; mon_sh = '0;
                mon_l = '0; mon_r = '0; mon_ur = 1'b0;
                mon_lr_err = 0; mon_pad_err = 0;
            end else begin
                if (mon_prev_bclk && !bclk) begin
                    mon_pos = (mon_pos + 1) % 64;
                    mon_k   = mon_pos % 32;
                    if (mon_pos == 0) begin
                        mon_ur = 1'b0; mon_lr_err = 0; mon_pad_err = 0;
                        frame_cnt++;
                    end
                    if (lrclk !== (mon_pos >= 32)) mon_lr_err++;
                    if (mon_k >= 1 && mon_k <= 24) mon_sh = {mon_sh[22:0], sdata};
                    else if (sdata !== 1'b0) mon_pad_err++;
                    if (mon_pos == 24) mon_l = mon_sh;
                    if (mon_pos == 56) mon_r = mon_sh;
                    if (mon_pos == 63)
                        frames.push_back('{l: mon_l, r: mon_r, ur: mon_ur,
                                           lr_err: mon_lr_err, pad_err: mon_pad_err});
                end
                if (underrun) begin
                    mon_ur = 1'b1;
                    ur_cnt++;
                end
                mon_prev_bclk = bclk;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [23:0] f, input logic uf, input logic of, input logic exp_sat);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", {31'd0, in_ready}, 32'd1);
        float_in = f; float_in_underflow = uf; float_in_overflow = of; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; float_in_underflow = 1'b0; float_in_overflow = 1'b0;
        chk("sat_pulse", {31'd0, sat}, {31'd0, exp_sat});
        @(negedge clk);
        chk("sat_clear", {31'd0, sat}, 32'd0);
    endtask

    // Skip underrun frames and check the first frame that carried a pair
    task automatic wait_frame(input string tag, input logic [23:0] el, input logic [23:0] er);
        frame_t fr;
        logic   found;
        int     n;
        found = 1'b0; n = 0;
        while (!found && n < 2000) begin
            if (frames.size() > 0) begin
                fr = frames.pop_front();
                if (!fr.ur) found = 1'b1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        chk({tag, "_found"}, {31'd0, found}, 32'd1);
        if (found) begin
            chk({tag, "_left"},  {8'd0, fr.l}, {8'd0, el});
            chk({tag, "_right"}, {8'd0, fr.r}, {8'd0, er});
            chk({tag, "_lrclk"}, fr.lr_err, 0);
            chk({tag, "_pad"},   fr.pad_err, 0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bclk"},     {31'd0, bclk},     32'd0);
        chk({tag, "_lrclk"},    {31'd0, lrclk},    32'd0);
        chk({tag, "_sdata"},    {31'd0, sdata},    32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_sat"},      {31'd0, sat},      32'd0);
        chk({tag, "_underrun"}, {31'd0, underrun}, 32'd0);
    endtask

    logic [23:0] bb[4];
    int          idx, n;
    logic        was_ready, last_bclk, rise_seen, found;
    frame_t      fr;

    initial begin
        rst = 1'b1; in_valid = 1'b0; float_in = '0;
        float_in_underflow = 1'b0; float_in_overflow = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        frame_cnt = 0; ur_cnt = 0; frames.delete();
        rst = 1'b0;

        // Frame 0 starts on the first bclk falling edge, 2*CLK_DIV clocks out
        repeat (2) @(negedge clk);
        chk("bclk_first_rise", {31'd0, bclk}, 32'd1);
        repeat (2) @(negedge clk);
        chk("bclk_first_fall", {31'd0, bclk}, 32'd0);
        chk("first_underrun", {31'd0, underrun}, 32'd1);
        chk("first_lrclk", {31'd0, lrclk}, 32'd0);

        // Idle: every frame is silent and flags underrun
        repeat (3 * 128 * CLK_DIV) @(negedge clk);
        chk("idle_frames", {31'd0, frame_cnt >= 3}, 32'd1);
        chk("idle_ur_cnt", ur_cnt, frame_cnt);
        while (frames.size() > 0) begin
            fr = frames.pop_front();
            chk("idle_zero", {8'd0, fr.l | fr.r}, 32'd0);
            chk("idle_ur", {31'd0, fr.ur}, 32'd1);
            chk("idle_pad", fr.pad_err, 0);
        end

        send(24'h3D8000, 1'b0, 1'b0, 1'b0);
        send(24'h000000, 1'b0, 1'b0, 1'b0);
        wait_frame("t_0375", 24'h300000, 24'h000000);

        send(24'h469040, 1'b0, 1'b0, 1'b1);
        send(24'hBE0000, 1'b0, 1'b0, 1'b0);
        wait_frame("t_sat_pos", 24'h7FFFFF, 24'hC00000);

        send(24'h3754C9, 1'b0, 1'b0, 1'b0);
        send(24'h3754C9, 1'b1, 1'b0, 1'b0);
        wait_frame("t_uflag", 24'h00AA64, 24'h000000);

        send(24'h7F0000, 1'b0, 1'b1, 1'b1);
        send(24'hBF0000, 1'b0, 1'b0, 1'b1);
        wait_frame("t_oflag", 24'h7FFFFF, 24'h800000);

        send(24'h280000, 1'b0, 1'b0, 1'b0);
        send(24'hB80000, 1'b0, 1'b0, 1'b0);
        wait_frame("t_e40_e56", 24'h000001, 24'hFF0000);

        send(24'h270000, 1'b0, 1'b0, 1'b0);
        send(24'hC00000, 1'b0, 1'b0, 1'b1);
        wait_frame("t_e39_e64", 24'h000000, 24'h800000);

        // Back-to-back stream: L0 R0 L1 R1 with in_valid held high
        bb[0] = 24'h3D8000; bb[1] = 24'hBE0000; bb[2] = 24'h3754C9; bb[3] = 24'h380000;
        frames.delete();
        idx = 0; n = 0; rise_seen = 1'b0;
        @(negedge clk); #1;
        float_in = bb[0]; in_valid = 1'b1;
        was_ready = in_ready; last_bclk = bclk;
        while (idx < 4 && n < 3000) begin
            @(negedge clk); #1;
            n++;
            if (was_ready) begin
                idx++;
                if (idx == 2) chk("bb_ready_low", {31'd0, in_ready}, 32'd0);
                if (idx < 4) float_in = bb[idx];
                else in_valid = 1'b0;
            end else if (idx == 2 && in_ready && !rise_seen) begin
                rise_seen = 1'b1;
                chk("bb_rise_pos", mon_pos, 0);
                chk("bb_rise_edge", {30'd0, last_bclk, bclk}, 32'd2);
            end
            was_ready = in_ready; last_bclk = bclk;
        end
        in_valid = 1'b0;
        chk("bb_done", idx, 4);
        chk("bb_rise_seen", {31'd0, rise_seen}, 32'd1);
        wait_frame("bb_pair0", 24'h300000, 24'hC00000);
        wait_frame("bb_pair1", 24'h00AA64, 24'h010000);

        // Reset at bit 40 of a live frame, with a second pair still pending
        frames.delete();
        send(24'h3D8000, 1'b0, 1'b0, 1'b0);
        send(24'h469040, 1'b0, 1'b0, 1'b1);
        send(24'h3D8000, 1'b0, 1'b0, 1'b0);
        send(24'h3D8000, 1'b0, 1'b0, 1'b0);
        found = 1'b0; n = 0;
        while (!found && n < 2000) begin
            @(negedge clk); #1;
            n++;
            if (mon_pos == 40 && !mon_ur && mon_l == 24'h300000) found = 1'b1;
        end
        chk("mid_found", {31'd0, found}, 32'd1);
        chk("mid_lrclk", {31'd0, lrclk}, 32'd1);
        chk("mid_sdata", {31'd0, sdata}, 32'd1);
        chk("mid_pending", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        repeat (2) @(negedge clk);
        frames.delete();
        rst = 1'b0;
        for (int f = 0; f < 2; f++) begin
            n = 0;
            while (frames.size() == 0 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            chk("post_rst_frame", {31'd0, frames.size() > 0}, 32'd1);
            if (frames.size() > 0) begin
                fr = frames.pop_front();
                chk("post_rst_zero", {8'd0, fr.l | fr.r}, 32'd0);
                chk("post_rst_ur", {31'd0, fr.ur}, 32'd1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
